// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and the PS/2 key path.
// Keys are queued and written into a mailbox word only in cycles where the CPU leaves memory idle.
module dmem_arbiter #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] KEY_BASE   = 32'h0000_0100,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_we,
  input  logic                        cpu_re,
  input  logic [DATA_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wd,
  output logic [DATA_W-1:0]           cpu_rd,
  input  logic                        key_ready,
  input  logic [7:0]                  mem_key,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_a,
  output logic [DATA_W-1:0]           mem_wd,
  input  logic [DATA_W-1:0]           mem_rd,
  output logic                        key_pending,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] key_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

  state_t            state, state_nxt;
  logic [7:0]        fifo [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count_nxt;
  logic [7:0]        seq;
  logic              key_q;
  logic              push, full, grant, accept, drop, clr;

  assign cpu_rd = mem_rd;

  assign push   = key_ready & ~key_q;
  assign full   = (key_count == (AW+1)'(FIFO_DEPTH));
  assign grant  = (state == PEND) & ~cpu_we & ~cpu_re;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign accept = push & (~full | grant);
  assign drop   = push & ~accept;
  assign clr    = cpu_we & (cpu_addr == KEY_BASE + DATA_W'(4)) & cpu_wd[0];

  assign count_nxt = key_count + (AW+1)'(accept) - (AW+1)'(grant);

  always_comb begin
    mem_we = cpu_we;
    mem_a  = cpu_addr;
    mem_wd = cpu_wd;
    if (grant) begin
      mem_we = 1'b1;
      mem_a  = KEY_BASE;
      mem_wd = DATA_W'({seq, fifo[rd_ptr]});
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_count != '0) state_nxt = PEND;
      PEND:    if (grant) state_nxt = HOLD;
      HOLD:    state_nxt = (key_count != '0) ? PEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      key_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      key_count   <= '0;
      key_pending <= 1'b0;
      overflow    <= 1'b0;
      seq         <= '0;
    end else begin
      state       <= state_nxt;
      key_q       <= key_ready;
      key_count   <= count_nxt;
      key_pending <= (count_nxt != '0);
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (grant) begin
        rd_ptr <= rd_ptr + AW'(1);
        seq    <= seq + 8'd1;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= mem_key;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a queue-based model;
// mailbox words are scored by a separate monitor.
module tb_dmem_arbiter;
  localparam int          DEPTH = 4;
  localparam logic [31:0] KB    = 32'h0000_0100;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cpu_we = 1'b0, cpu_re = 1'b0, key_ready = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wd = '0, mem_rd = '0;
  logic [7:0]  mem_key = '0;
  logic [31:0] cpu_rd, mem_a, mem_wd;
  logic        mem_we, key_pending, overflow;
  logic [2:0]  key_count;

  int checks = 0, errors = 0;

  // reference model state
  logic [31:0] exp_q[$];
  int          m_cnt;
  logic        m_ovf, m_prev_ne, m_prev_wr, m_prev_key;
  logic [7:0]  m_tag;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .KEY_BASE(KB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .key_ready(key_ready), .mem_key(mem_key),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .key_pending(key_pending), .overflow(overflow), .key_count(key_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every key write the DUT presents must match the next accepted key in order.
  always @(negedge clk) begin
    if (rst && mem_we && !cpu_we && mem_a == KB) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mailbox_unexpected: got %h expected no write at %0t", mem_wd, $time);
      end else begin
        chk("mailbox_word", mem_wd, exp_q.pop_front());
      end
    end
  end

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic wr, push, drop;
    mem_rd = $urandom;
    @(negedge clk);
    chk("key_count", 32'(key_count), 32'(m_cnt));
    chk("key_pending", 32'(key_pending), 32'(m_cnt != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("cpu_rd", cpu_rd, mem_rd);
    // A key write needs a CPU-free cycle, a key queued now and in the previous cycle,
    // and no key write in the previous cycle.
    wr = !cpu_we && !cpu_re && m_cnt != 0 && m_prev_ne && !m_prev_wr;
    chk("mem_we", 32'(mem_we), 32'(wr ? 1'b1 : cpu_we));
    chk("mem_a", mem_a, wr ? KB : cpu_addr);
    if (!wr) chk("mem_wd", mem_wd, cpu_wd);
    @(posedge clk);
    m_prev_ne = (m_cnt != 0);
    if (wr) m_cnt--;
    push = key_ready && !m_prev_key;
    drop = 1'b0;
    if (push) begin
      if (m_cnt < DEPTH) begin
        m_cnt++;
        exp_q.push_back({16'h0, m_tag, mem_key});
        m_tag++;
      end else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (cpu_we && cpu_addr == KB + 32'd4 && cpu_wd[0]) m_ovf = 1'b0;
    m_prev_wr  = wr;
    m_prev_key = key_ready;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_key_count", 32'(key_count), 32'd0);
    chk("rst_key_pending", 32'(key_pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'(cpu_we));
    chk("rst_mem_a", mem_a, cpu_addr);
    m_cnt = 0; m_ovf = 1'b0; m_prev_ne = 1'b0; m_prev_wr = 1'b0; m_prev_key = 1'b0;
    m_tag = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic key(input logic [7:0] k);
    mem_key = k; key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    cpu_we = 1'b0; cpu_re = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #2;
    do_reset();

    // held level gives one mailbox write
    mem_key = 8'h1C; key_ready = 1'b1;
    repeat (3) tick();
    key_ready = 1'b0;
    idle(4);

    // key waits behind CPU loads
    cpu_re = 1'b1; mem_key = 8'h2A; key_ready = 1'b1;
    cpu_addr = $urandom; tick();
    key_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin cpu_addr = $urandom; tick(); end
    idle(4);

    // overflow under continuous stores, then drain
    cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wd = $urandom;
    for (int i = 0; i < 5; i++) key(8'h10 + 8'(i));
    idle(12);

    // clear, then drop and clear in the same cycle
    cpu_we = 1'b1; cpu_addr = KB + 32'd4; cpu_wd = 32'h1;
    tick();
    for (int i = 0; i < 5; i++) key(8'h20 + 8'(i));
    idle(12);

    // full FIFO, granted pop and new key edge in the same cycle
    cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wd = 32'h0;
    for (int i = 0; i < 4; i++) key(8'h30 + 8'(i));
    cpu_we = 1'b0; mem_key = 8'h34; key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    idle(12);

    // seq wrap: 257 keys from reset, last one carries seq 0
    do_reset();
    for (int i = 0; i < 257; i++) begin
      key(8'(i));
      idle(2);
    end

    // reset while a key write is being granted
    cpu_re = 1'b1; mem_key = 8'h5A; key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    repeat (2) tick();
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h300;
    #1;
    chk("grant_mem_we", 32'(mem_we), 32'd1);
    chk("grant_mem_wd", mem_wd, {16'h0, m_tag - 8'd1, 8'h5A});
    do_reset();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cpu_we   = ($urandom_range(0, 3) == 0);
      cpu_re   = !cpu_we && ($urandom_range(0, 3) == 0);
      cpu_addr = ($urandom_range(0, 5) == 0) ? KB + 32'd4 : ($urandom & 32'hFFFF_FFFC);
      cpu_wd   = $urandom;
      mem_key  = 8'($urandom);
      if ($urandom_range(0, 2) == 0) key_ready = ~key_ready;
      tick();
    end
    key_ready = 1'b0;
    idle(16);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
